// File: rtl/prog_loader.sv
// prog_loader: serial program loader for the instruction ROM.
//
// Packs a UART byte stream into DW-bit words (MSB first). It writes them into
// the instruction ROM starting at address 0. The CPU is held in reset while a
// frame is loading. The CPU is released only when the frame's XOR checksum
// matches.
//
// Frame format: 0xA5 | N[15:8] | N[7:0] | N x {hi,lo} | CHK
//   CHK = XOR of the 2N data bytes, starting from 8'h00.
//
// Ports:
//   clk50m     in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   rx_data    in   8   received byte, qualified by rx_valid
//   rx_valid   in   1   one-cycle strobe per received byte
//   rx_err     in   1   one-cycle strobe, UART framing error
//   rom_we     out  1   ROM write strobe, one cycle per word
//   rom_addr   out  PW  ROM write address
//   rom_wdata  out  DW  ROM write data
//   cpu_rst_n  out  1   CPU hold, active low
//   busy       out  1   frame in progress
//   done       out  1   sticky: last frame loaded with good checksum
//   err        out  1   sticky: last frame aborted
module prog_loader #(
  parameter int DW     = 16,
  parameter int PW     = 15,
  parameter int TO_CYC = 5_000_000
) (
  input  logic          clk50m,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          rx_err,
  output logic          rom_we,
  output logic [PW-1:0] rom_addr,
  output logic [DW-1:0] rom_wdata,
  output logic          cpu_rst_n,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int          TW      = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);
  localparam logic [7:0]  SOF     = 8'hA5;
  // Largest legal word count: a full 2**PW-word ROM.
  localparam logic [31:0] N_MAX   = 32'd1 << PW;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CNT_H = 3'd1,
    S_CNT_L = 3'd2,
    S_DAT_H = 3'd3,
    S_DAT_L = 3'd4,
    S_CHK   = 3'd5
  } state_t;

  // Running checksum update, one byte at a time.
  function automatic logic [7:0] chk_accum(input logic [7:0] acc, input logic [7:0] b);
    chk_accum = acc ^ b;
  endfunction

  state_t        state_q, state_d;
  logic [7:0]    n_hi_q, n_hi_d;
  logic [PW:0]   n_q, n_d;        // PW+1 bits so N = 2**PW fits
  logic [PW:0]   idx_q, idx_d;
  logic [7:0]    hi_q, hi_d;
  logic [7:0]    acc_q, acc_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          rom_we_q, rom_we_d;
  logic [PW-1:0] rom_addr_q, rom_addr_d;
  logic [DW-1:0] rom_wdata_q, rom_wdata_d;
  logic          cpu_rst_n_q, cpu_rst_n_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [31:0]   n_full_s;
  logic [PW:0]   idx_inc_s;
  logic          abort_s;

  assign n_full_s  = {16'h0000, n_hi_q, rx_data};
  assign idx_inc_s = idx_q + (PW+1)'(1);

  // Next-state and next-output computation for the loader FSM.
  always_comb begin
    state_d     = state_q;
    n_hi_d      = n_hi_q;
    n_d         = n_q;
    idx_d       = idx_q;
    hi_d        = hi_q;
    acc_d       = acc_q;
    to_cnt_d    = to_cnt_q;
    rom_we_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;
    cpu_rst_n_d = cpu_rst_n_q;
    done_d      = done_q;
    err_d       = err_q;
    abort_s     = 1'b0;

    if (state_q == S_IDLE) begin
      // rx_err is ignored here; only a start-of-frame byte matters.
      to_cnt_d = '0;
      if (rx_valid && (rx_data == SOF)) begin
        state_d     = S_CNT_H;
        done_d      = 1'b0;
        err_d       = 1'b0;
        idx_d       = '0;
        acc_d       = 8'h00;
        cpu_rst_n_d = 1'b0;
      end else begin
        state_d = S_IDLE;
      end
    end else if (rx_err) begin
      // Framing error beats a byte arriving in the same cycle.
      abort_s = 1'b1;
    end else if (rx_valid) begin
      // A byte beats timeout expiry in the same cycle; 0xA5 here is plain data.
      to_cnt_d = '0;
      case (state_q)
        S_CNT_H: begin
          n_hi_d  = rx_data;
          state_d = S_CNT_L;
        end
        S_CNT_L: begin
          if (n_full_s > N_MAX) begin
            abort_s = 1'b1;
          end else if (n_full_s == 32'd0) begin
            n_d     = '0;
            state_d = S_CHK;
          end else begin
            n_d     = n_full_s[PW:0];
            state_d = S_DAT_H;
          end
        end
        S_DAT_H: begin
          hi_d    = rx_data;
          acc_d   = chk_accum(acc_q, rx_data);
          state_d = S_DAT_L;
        end
        S_DAT_L: begin
          acc_d       = chk_accum(acc_q, rx_data);
          rom_we_d    = 1'b1;
          rom_addr_d  = idx_q[PW-1:0];
          rom_wdata_d = {hi_q, rx_data};
          idx_d       = idx_inc_s;
          if (idx_inc_s == n_q) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DAT_H;
          end
        end
        S_CHK: begin
          if (rx_data == acc_q) begin
            done_d      = 1'b1;
            cpu_rst_n_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            abort_s = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else if (to_cnt_q == TO_LAST) begin
      abort_s = 1'b1;
    end else begin
      to_cnt_d = to_cnt_q + TW'(1);
    end

    // Abort leaves cpu_rst_n low so a partially written ROM never runs.
    if (abort_s) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      done_d  = 1'b0;
    end else begin
      err_d = err_d;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      n_hi_q      <= 8'h00;
      n_q         <= '0;
      idx_q       <= '0;
      hi_q        <= 8'h00;
      acc_q       <= 8'h00;
      to_cnt_q    <= '0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      cpu_rst_n_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_hi_q      <= n_hi_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      hi_q        <= hi_d;
      acc_q       <= acc_d;
      to_cnt_q    <= to_cnt_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign rom_we    = rom_we_q;
  assign rom_addr  = rom_addr_q;
  assign rom_wdata = rom_wdata_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: directed frames with a queue of expected ROM writes.
module tb_prog_loader;

  localparam int PW = 15;
  localparam int DW = 16;
  localparam int TO = 16;

  logic          clk50m = 1'b0;
  logic          rst_n  = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_err = 1'b0;
  logic          rom_we;
  logic [PW-1:0] rom_addr;
  logic [DW-1:0] rom_wdata;
  logic          cpu_rst_n;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [PW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];

  prog_loader #(.DW(DW), .PW(PW), .TO_CYC(TO)) dut (
    .clk50m   (clk50m),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .rom_we   (rom_we),
    .rom_addr (rom_addr),
    .rom_wdata(rom_wdata),
    .cpu_rst_n(cpu_rst_n),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #10 clk50m = ~clk50m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rom_we"},    {31'd0, rom_we},    32'd0);
    chk({tag, "_rom_addr"},  {17'd0, rom_addr},  32'd0);
    chk({tag, "_rom_wdata"}, {16'd0, rom_wdata}, 32'd0);
    chk({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd1);
    chk({tag, "_busy"},      {31'd0, busy},      32'd0);
    chk({tag, "_done"},      {31'd0, done},      32'd0);
    chk({tag, "_err"},       {31'd0, err},       32'd0);
  endtask

  // Called just after a falling edge; the byte is taken on the next rising edge.
  task automatic send(input logic [7:0] b, input logic e);
    rx_data  = b;
    rx_valid = 1'b1;
    rx_err   = e;
    @(negedge clk50m);
    rx_valid = 1'b0;
    rx_err   = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send(8'hA5, 1'b0);
    send(n[15:8], 1'b0);
    send(n[7:0], 1'b0);
  endtask

  task automatic send_word(input logic [PW-1:0] a, input logic [7:0] hi, input logic [7:0] lo);
    send(hi, 1'b0);
    exp_q.push_back('{addr: a, data: {hi, lo}});
    send(lo, 1'b0);
  endtask

  // Every ROM write is matched against the oldest expected write.
  always @(negedge clk50m) begin
    if (rom_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rom_we_unexpected", {31'd0, rom_we}, 32'd0);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("rom_addr", {17'd0, rom_addr}, {17'd0, w.addr});
        chk("rom_wdata", {16'd0, rom_wdata}, {16'd0, w.data});
      end
    end
  end

  initial begin
    // Reset state.
    repeat (2) @(negedge clk50m);
    chk_reset_vals("in_reset");
    rst_n = 1'b1;
    @(negedge clk50m);
    chk_reset_vals("after_reset");

    // Garbage in IDLE, including a framing error, changes nothing.
    send(8'h00, 1'b0);
    send(8'hFF, 1'b0);
    send(8'h5A, 1'b1);
    chk("garbage_busy", {31'd0, busy}, 32'd0);
    chk("garbage_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
    chk("garbage_err", {31'd0, err}, 32'd0);

    // Good two-word frame; 12^34^AB^CD = 40.
    send(8'hA5, 1'b0);
    chk("sof_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    chk("sof_busy", {31'd0, busy}, 32'd1);
    send(8'h00, 1'b0);
    send(8'h02, 1'b0);
    send_word(15'd0, 8'h12, 8'h34);
    send_word(15'd1, 8'hAB, 8'hCD);
    chk("pre_chk_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    send(8'h40, 1'b0);
    chk("good_done", {31'd0, done}, 32'd1);
    chk("good_err", {31'd0, err}, 32'd0);
    chk("good_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
    chk("good_busy", {31'd0, busy}, 32'd0);
    chk("good_writes_seen", exp_q.size(), 32'd0);

    // Same frame with a wrong checksum: writes happen, CPU stays held.
    send_hdr(16'd2);
    send_word(15'd0, 8'h12, 8'h34);
    send_word(15'd1, 8'hAB, 8'hCD);
    send(8'h41, 1'b0);
    chk("badchk_err", {31'd0, err}, 32'd1);
    chk("badchk_done", {31'd0, done}, 32'd0);
    chk("badchk_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    chk("badchk_writes_seen", exp_q.size(), 32'd0);

    // Resend correctly.
    send_hdr(16'd2);
    send_word(15'd0, 8'h12, 8'h34);
    send_word(15'd1, 8'hAB, 8'hCD);
    send(8'h40, 1'b0);
    chk("resend_done", {31'd0, done}, 32'd1);
    chk("resend_err", {31'd0, err}, 32'd0);
    chk("resend_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);

    // Empty frame: no writes, checksum 00.
    send_hdr(16'd0);
    send(8'h00, 1'b0);
    chk("empty_done", {31'd0, done}, 32'd1);
    chk("empty_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);

    // Timeout after the high byte of a word.
    send_hdr(16'd1);
    send(8'h12, 1'b0);
    repeat (TO - 1) @(negedge clk50m);
    chk("to_pre_err", {31'd0, err}, 32'd0);
    chk("to_pre_busy", {31'd0, busy}, 32'd1);
    @(negedge clk50m);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_busy", {31'd0, busy}, 32'd0);
    chk("to_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);

    // Oversize count N = 2**PW + 1.
    send_hdr(16'h8001);
    chk("oversize_err", {31'd0, err}, 32'd1);
    chk("oversize_busy", {31'd0, busy}, 32'd0);

    // N = 2**PW is legal; then a framing error together with the low byte aborts with no write.
    send_hdr(16'h8000);
    chk("nmax_err", {31'd0, err}, 32'd0);
    chk("nmax_busy", {31'd0, busy}, 32'd1);
    send(8'h12, 1'b0);
    send(8'h34, 1'b1);
    chk("rxerr_err", {31'd0, err}, 32'd1);
    chk("rxerr_busy", {31'd0, busy}, 32'd0);
    chk("rxerr_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);

    // Byte arriving in the very cycle the timeout would expire is accepted.
    send_hdr(16'd1);
    send(8'h12, 1'b0);
    repeat (TO - 1) @(negedge clk50m);
    exp_q.push_back('{addr: 15'd0, data: 16'h1234});
    send(8'h34, 1'b0);
    chk("edge_err", {31'd0, err}, 32'd0);
    chk("edge_busy", {31'd0, busy}, 32'd1);
    send(8'h26, 1'b0);
    chk("edge_done", {31'd0, done}, 32'd1);
    chk("edge_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);

    // Asynchronous reset while waiting for a low byte.
    send_hdr(16'd2);
    send(8'hAB, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    @(negedge clk50m);
    rst_n = 1'b1;
    send(8'hCD, 1'b0);
    repeat (2) @(negedge clk50m);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);
    chk("post_reset_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
    chk("final_writes_seen", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
